pcpi_simd8: RTL

PCPI_SIMD8 -- requirements
Module: pcpi_simd8

---
 rtl/pcpi_simd8_pkg.sv | 37 +++
 rtl/pcpi_simd8_mac.sv | 27 ++
 rtl/pcpi_simd8.sv | 101 ++++++++++
 3 files changed

// File: rtl/pcpi_simd8_pkg.sv
// Shared constants, FSM state type and the single-cycle lane ALU for the
// packed 4x8-bit PCPI SIMD coprocessor.
package pcpi_simd8_pkg;

  localparam logic [6:0] OPCODE_CUSTOM_DEF = 7'b0001011;
  localparam logic [6:0] FUNCT7_SIMD       = 7'b0000000;

  localparam logic [2:0] VADD8  = 3'b000;
  localparam logic [2:0] VSUB8  = 3'b001;
  localparam logic [2:0] VMAX8U = 3'b010;
  localparam logic [2:0] VDOT8  = 3'b011;
  localparam logic [2:0] VSAD8  = 3'b100;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_COOL} state_e;

  // Lane-parallel ops; carries never cross lane boundaries.
  function automatic logic [31:0] simd_alu(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      unique case (f3)
        VADD8:  r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
        VSUB8:  r[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] - b[i*LANE_W +: LANE_W];
        VMAX8U: r[i*LANE_W +: LANE_W] = (a[i*LANE_W +: LANE_W] > b[i*LANE_W +: LANE_W]) ?
                                        a[i*LANE_W +: LANE_W] : b[i*LANE_W +: LANE_W];
        default: r[i*LANE_W +: LANE_W] = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/pcpi_simd8_mac.sv
// One serial lane step: select a byte lane of each operand and add either the
// signed product or the unsigned absolute difference to the accumulator.
module pcpi_simd8_mac
  import pcpi_simd8_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  lane,
  input  logic        dot,
  input  logic [31:0] acc,
  output logic [31:0] acc_next
);

  logic [LANE_W-1:0] a, b, ad;
  logic signed [15:0] prod;
  logic [31:0]        step;

  assign a    = rs1[lane*LANE_W +: LANE_W];
  assign b    = rs2[lane*LANE_W +: LANE_W];
  assign prod = $signed(a) * $signed(b);
  assign ad   = (a >= b) ? (a - b) : (b - a);

  // Product is sign-extended so the 32-bit sum stays two's complement.
  assign step     = dot ? {{16{prod[15]}}, prod} : {24'd0, ad};
  assign acc_next = acc + step;

endmodule

// File: rtl/pcpi_simd8.sv
// PCPI coprocessor for packed 4x8-bit SIMD ops: add/sub/umax complete in one
// cycle, dot-product and SAD fold one lane per cycle through the MAC.
module pcpi_simd8
  import pcpi_simd8_pkg::*;
#(
  parameter logic [6:0] OPCODE_CUSTOM       = OPCODE_CUSTOM_DEF,
  parameter int         MAC_LANES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  state_e      state;
  logic [1:0]  cnt;
  logic [31:0] acc, acc_next;
  logic        op_dot;
  logic [2:0]  f3;
  logic        claim, serial;
  logic        unused_insn;

  assign f3          = pcpi_insn[14:12];
  assign claim       = pcpi_valid && (pcpi_insn[6:0] == OPCODE_CUSTOM) &&
                       (pcpi_insn[31:25] == FUNCT7_SIMD) && (f3 <= VSAD8);
  assign serial      = (f3 == VDOT8) || (f3 == VSAD8);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  pcpi_simd8_mac u_mac (
    .rs1      (pcpi_rs1),
    .rs2      (pcpi_rs2),
    .lane     (cnt),
    .dot      (op_dot),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      op_dot     <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
    end else begin
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_ready <= 1'b0;
      unique case (state)
        S_IDLE: if (claim) begin
          if (serial) begin
            state     <= S_BUSY;
            cnt       <= '0;
            acc       <= '0;
            op_dot    <= (f3 == VDOT8);
            pcpi_wait <= 1'b1;
          end else begin
            state      <= S_DONE;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= simd_alu(f3, pcpi_rs1, pcpi_rs2);
          end
        end
        S_BUSY: begin
          // Core withdrawing the instruction wins over finishing the last lane.
          if (!pcpi_valid) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            pcpi_wait <= 1'b0;
          end else if (cnt == 2'(LANES - 1)) begin
            state      <= S_DONE;
            cnt        <= '0;
            acc        <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= acc_next;
          end else begin
            cnt <= cnt + 2'(MAC_LANES_PER_CYCLE);
            acc <= acc_next;
          end
        end
        S_DONE: state <= S_COOL;
        // One dead cycle so a valid still held from the finished insn is not re-claimed.
        S_COOL: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
